// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl -- bit-serial sequencer for a single external 1-bit ALU slice.
//
// Accepts a WIDTH-bit operation in IDLE, then feeds the slice one bit per
// clock (LSB first) for WIDTH cycles. It collects one result bit per cycle
// and owns the carry chain between bits.
//
// Optional feature macro: ALU_SERIAL_SUB_EN
//   defined   -> op 3'b101 is SUB (b inverted, initial carry 1, issued as ADD)
//   undefined -> op 3'b101 is rejected like 3'b110/3'b111
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, op, a, b    request; operands sampled only on the accepting edge
//   busy               high while bits are being processed (RUN)
//   done, err          one-cycle completion pulse; err marks a rejected op
//   result             final result, held until the next accepted start
//   carry_out          final carry for ADD/SUB, 0 for logic ops
//   overflow           signed overflow for ADD/SUB, 0 otherwise
//   slice_a/b/cin/op   bit operands, carry and opcode to the slice (0 outside RUN)
//   slice_result       combinational result bit returned by the slice
module alu_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [2:0]       slice_op,
    input  logic             slice_result
);

    localparam int unsigned       IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [2:0]        OP_ADD   = 3'b100;
`ifdef ALU_SERIAL_SUB_EN
    localparam logic [2:0]        OP_SUB   = 3'b101;
    localparam logic [2:0]        OP_MAX   = OP_SUB;
`else
    localparam logic [2:0]        OP_MAX   = OP_ADD;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q, overflow_d;
    logic               err_q, err_d;
    logic               is_sub_c;
    logic               is_arith_c;
    logic               carry_nxt_c;

    // Opcode class of the operation in flight
    always_comb begin
`ifdef ALU_SERIAL_SUB_EN
        is_sub_c   = (op_q == OP_SUB);
`else
        is_sub_c   = 1'b0;
`endif
        is_arith_c = (op_q == OP_ADD) || is_sub_c;
    end

    // Next-state, datapath update and slice drive
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        err_d       = err_q;
        slice_a     = 1'b0;
        slice_b     = 1'b0;
        slice_cin   = 1'b0;
        slice_op    = 3'b000;
        carry_nxt_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    result_d    = '0;
                    carry_out_d = 1'b0;
                    overflow_d  = 1'b0;
                    if (op <= OP_MAX) begin
                        a_d     = a;
                        b_d     = b;
                        op_d    = op;
                        idx_d   = '0;
`ifdef ALU_SERIAL_SUB_EN
                        carry_d = (op == OP_SUB);
`else
                        carry_d = 1'b0;
`endif
                        err_d   = 1'b0;
                        state_d = ST_RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_RUN: begin
                slice_a     = a_q[idx_q];
                slice_b     = b_q[idx_q] ^ is_sub_c;
                slice_cin   = carry_q;
                slice_op    = is_sub_c ? OP_ADD : op_q;
                carry_nxt_c = (slice_a & slice_b) | (slice_a & carry_q) | (slice_b & carry_q);
                result_d[idx_q] = slice_result;
                carry_d     = carry_nxt_c;
                idx_d       = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    // carry_q here is the carry into the MSB
                    carry_out_d = is_arith_c & carry_nxt_c;
                    overflow_d  = is_arith_c & (carry_q ^ carry_nxt_c);
                    idx_d       = '0;
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 3'b000;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            err_q       <= err_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Testbench for alu_serial_ctrl: behavioural 1-bit slice, vector table,
// hand-written corner sequences and randomized ops against a reference model.
module tb_alu_serial_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, err;
    logic [W-1:0] result;
    logic         carry_out, overflow;
    logic         slice_a, slice_b, slice_cin;
    logic [2:0]   slice_op;
    logic         slice_result;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .result       (result),
        .carry_out    (carry_out),
        .overflow     (overflow),
        .slice_a      (slice_a),
        .slice_b      (slice_b),
        .slice_cin    (slice_cin),
        .slice_op     (slice_op),
        .slice_result (slice_result)
    );

    // Behavioural 1-bit ALU slice
    always_comb begin
        case (slice_op)
            3'b000:  slice_result = slice_a & slice_b;
            3'b001:  slice_result = slice_a | slice_b;
            3'b010:  slice_result = slice_a ^ slice_b;
            3'b011:  slice_result = ~(slice_a | slice_b);
            3'b100:  slice_result = slice_a ^ slice_b ^ slice_cin;
            default: slice_result = 1'b0;
        endcase
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Whole-word reference of one operation
    function automatic void ref_model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                      output logic [W-1:0] r, output logic co, output logic ov,
                                      output logic er);
        logic [W:0] s;
        r = '0; co = 1'b0; ov = 1'b0; er = 1'b0;
        case (o)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: r = x ^ y;
            3'd3: r = ~(x | y);
            3'd4: begin
                s  = {1'b0, x} + {1'b0, y};
                r  = s[W-1:0];
                co = s[W];
                ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
`ifdef ALU_SERIAL_SUB_EN
            3'd5: begin
                r  = x - y;
                co = (x >= y);
                ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
`endif
            default: er = 1'b1;
        endcase
    endfunction

    // Carry into bit i of x + y + c0
    function automatic logic cin_at(input logic [W-1:0] x, input logic [W-1:0] y, input logic c0,
                                    input int i);
        logic [63:0] m, s;
        m = (64'd1 << i) - 64'd1;
        s = (64'(x) & m) + (64'(y) & m) + 64'(c0);
        return s[i];
    endfunction

    // Issue one op, follow it through RUN, check completion; inj >= 0 pulses a
    // stray start with other operands at that RUN cycle index.
    task automatic do_op(input string nm, input logic [2:0] o, input logic [W-1:0] aa,
                         input logic [W-1:0] bb, input logic [W-1:0] e_res, input logic e_co,
                         input logic e_ov, input logic e_err, input int inj);
        int           lat;
        int           bcnt;
        logic         sub;
        logic [W-1:0] bx;
        sub = 1'b0;
`ifdef ALU_SERIAL_SUB_EN
        sub = (o == 3'b101);
`endif
        bx = sub ? ~bb : bb;
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        lat = 0; bcnt = 0;
        while (!done && lat <= int'(W) + 2) begin
            if (busy) bcnt++;
            if (lat < int'(W)) begin
                check({nm, " slice_a"}, 64'(slice_a), 64'(aa[lat]));
                check({nm, " slice_b"}, 64'(slice_b), 64'(bx[lat]));
                check({nm, " slice_op"}, 64'(slice_op), 64'(sub ? 3'b100 : o));
                if (o == 3'b100 || sub)
                    check({nm, " slice_cin"}, 64'(slice_cin), 64'(cin_at(aa, bx, sub, lat)));
            end
            if (lat == inj) begin
                start = 1'b1; op = 3'b000; a = ~aa; b = ~bb;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({nm, " latency"}, 64'(lat + 1), 64'(e_err ? 1 : int'(W) + 1));
        check({nm, " busy_cycles"}, 64'(bcnt), 64'(e_err ? 0 : int'(W)));
        check({nm, " done"}, 64'(done), 64'd1);
        check({nm, " err"}, 64'(err), 64'(e_err));
        check({nm, " result"}, 64'(result), 64'(e_res));
        check({nm, " carry_out"}, 64'(carry_out), 64'(e_co));
        check({nm, " overflow"}, 64'(overflow), 64'(e_ov));
        @(posedge clk); #1;
        check({nm, " done_one_cycle"}, 64'({done, err, busy}), 64'd0);
        check({nm, " result_held"}, 64'({result, carry_out, overflow}), 64'({e_res, e_co, e_ov}));
        check({nm, " slice_idle"}, 64'({slice_a, slice_b, slice_cin, slice_op}), 64'd0);
    endtask

    typedef struct {
        string        nm;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        logic         err;
    } vec_t;

    vec_t vt[10];

    initial begin
        int           ndone;
        logic [2:0]   ro;
        logic [W-1:0] rx, ry, rr;
        logic         rco, rov, rer;

        vt[0] = '{"add_7f_01", 3'd4, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
        vt[1] = '{"and_f0_3c", 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
        vt[2] = '{"nor_f0_0f", 3'd3, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[3] = '{"or_a0_05",  3'd1, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b0};
        vt[4] = '{"xor_ff_0f", 3'd2, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0};
        vt[5] = '{"op111",     3'd7, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1};
        vt[6] = '{"add_ff_01", 3'd4, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};
        vt[7] = '{"add_80_80", 3'd4, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[8] = '{"op110",     3'd6, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b0, 1'b1};
`ifdef ALU_SERIAL_SUB_EN
        vt[9] = '{"sub_05_07", 3'd5, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0};
`else
        vt[9] = '{"op101_off", 3'd5, 8'h05, 8'h07, 8'h00, 1'b0, 1'b0, 1'b1};
`endif

        rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'({busy, done, err, result, carry_out, overflow,
                                    slice_a, slice_b, slice_cin, slice_op}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            do_op(vt[i].nm, vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].co, vt[i].ov, vt[i].err, -1);

        // Stray start in RUN cycle 3 must be ignored
        do_op("start_in_run", 3'd4, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 2);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("no_extra_done", 64'(ndone), 64'd0);
        check("start_in_run result_kept", 64'(result), 64'h80);

        // Reset in RUN cycle 4 clears everything and produces no done
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 8'hFF; b = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid outputs", 64'({busy, done, err, result, carry_out, overflow,
                                      slice_a, slice_b, slice_cin, slice_op}), 64'd0);
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("rst_mid no_done", 64'(ndone), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("add_after_rst", 3'd4, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, -1);

        // Randomized ops against the reference model
        for (int i = 0; i < 200; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = W'($urandom);
            ry = W'($urandom);
            if ($urandom_range(0, 3) == 0) rx = '1;
            if ($urandom_range(0, 5) == 0) ry = rx;
            ref_model(ro, rx, ry, rr, rco, rov, rer);
            do_op("rand", ro, rx, ry, rr, rco, rov, rer, -1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Bit-serial sequencer for the 1-bit ALU slice: accepts a WIDTH-bit operation, then drives the external slice once per clock, LSB first, for WIDTH cycles, collecting one result bit per cycle. Owns the slice's carry chain (carry register), operand shifting, opcode and handshake. Sits between a requester (register file or test driver) and a single `alu_1_bit` instance, so a wide ALU operation needs only one slice.

## Interface
- `WIDTH`, default 8: operand/result width, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; accepted only in IDLE.
- `op` in 3: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB (macro-gated), 110/111 invalid.
- `a`, `b` in WIDTH: operands, sampled on the accepting edge only.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse in DONE.
- `err` out 1: one-cycle pulse with `done` for a rejected op.
- `result` out WIDTH: final result, held until next accepted start.
- `carry_out` out 1: final carry (ADD/SUB), 0 for logic ops.
- `overflow` out 1: signed overflow (ADD/SUB), 0 otherwise.
- `slice_a`, `slice_b`, `slice_cin` out 1: bit operands and carry to the slice.
- `slice_op` out 3: slice opcode (SUB issued as ADD).
- `slice_result` in 1: combinational result bit from the slice.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all outputs and internal registers 0.
- IDLE + `start` with valid op: latch `a`, `b`, `op`; bit index ← 0; carry ← 1 for SUB, else 0; clear `result`, `carry_out`, `overflow`; → RUN.
- IDLE + `start` with invalid op: `result` ← 0, `carry_out`/`overflow` ← 0; → DONE with `err` set.
- RUN, each cycle: `slice_a` = a_reg[idx]; `slice_b` = b_reg[idx] (inverted for SUB); `slice_cin` = carry; on edge, `result[idx]` ← `slice_result`; carry ← maj(slice_a, slice_b, carry); idx ← idx+1.
- RUN at idx = WIDTH-1: `carry_out` ← next carry; `overflow` ← carry into MSB XOR next carry (ADD/SUB only); → DONE.
- DONE: `done` = 1 (`err` = 1 if rejected), → IDLE unconditionally.
- `start` in RUN or DONE: ignored, no queueing; operands not resampled.
- Outside RUN: `slice_*` outputs driven 0.
- Carry arithmetic is modulo 2^WIDTH; idx counter is ceil(log2(WIDTH)) bits and does not wrap inside an operation.
- `rst_n` low mid-operation: immediately IDLE, partial result discarded, outputs 0, no `done`.

## Timing
- Start accepted at edge E0; RUN occupies the cycles after E0 through E_WIDTH; `done` high in the cycle after edge E_WIDTH; back in IDLE after E_WIDTH+1.
- Accept-to-`done` latency: WIDTH+1 cycles; throughput one op per WIDTH+2 cycles (earliest new start in the cycle `done` falls).
- Invalid op: `done`/`err` in the cycle after E0 (latency 1).
- `result`/`carry_out`/`overflow` valid when `done` is high and stable thereafter.
- `slice_result` is sampled the same cycle its inputs are driven (combinational slice, single-cycle path).

## Configuration
- `ALU_SERIAL_SUB_EN` defined: op 101 = SUB (b inverted, initial carry 1); `carry_out` = 1 means no borrow.
- Undefined: op 101 is invalid (same handling as 110/111: `err` + `done`, result 0); no inverter logic synthesized.

## Test plan
- WIDTH=8, ADD 8'h7F + 8'h01 → `result` 8'h80, `carry_out` 0, `overflow` 1, `done` exactly 9 cycles after accepting edge, `busy` high 8 cycles.
- AND 8'hF0 & 8'h3C → 8'h30; NOR 8'hF0, 8'h0F → 8'h00; `carry_out`/`overflow` 0.
- With `ALU_SERIAL_SUB_EN`: SUB 8'h05 - 8'h07 → 8'hFE, `carry_out` 0, `overflow` 0. Without: op 101 → `err`+`done` next cycle, `result` 0.
- `start` pulsed in cycle 3 of RUN with different operands → ignored; first op result unchanged, no extra `done`.
- `rst_n` low at RUN cycle 4 of ADD 8'hFF + 8'h01 → all outputs 0 immediately, no `done`; new ADD 8'h01 + 8'h01 after release → 8'h02.
- Op 3'b111 → `err` and `done` together for one cycle, latency 1, `busy` never high.
